exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit.sv | 121 ++++++++++++
 tb/tb_exec_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: MIPS-style integer execute unit with single-cycle ALU ops and iterative MULTU/DIVU into HI/LO.
module exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [5:0]       func,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  localparam logic [SHW:0] last = (SHW+1)'(WIDTH);
  state_t state, state_n;
  logic [SHW:0] cnt;
  logic [2*WIDTH-1:0] p, mstep, dstep;
  logic [WIDTH-1:0] d, alu;
  logic [WIDTH:0] msum;
  logic [2*WIDTH:0] dsh;
  logic [WIDTH+1:0] ddiff;
  logic ill, is_mul, is_div, acc, done;
  assign in_ready = (state == IDLE);
  assign acc = in_valid && in_ready;
  assign done = (state != IDLE) && (cnt == last);
  always_comb begin
    alu = '0;
    ill = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (aluop)
      3'b000:
        case (func)
          6'b100000: alu = a + b;
          6'b100010: alu = a - b;
          6'b100100: alu = a & b;
          6'b100101: alu = a | b;
          6'b100111: alu = ~(a | b);
          6'b101010: alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
          6'b000000: alu = b << shamt;
          6'b000010: alu = b >> shamt;
          6'b011001: is_mul = 1'b1;
          6'b011011: is_div = 1'b1;
          6'b010000: alu = hi;
          6'b010010: alu = lo;
          default:   ill = 1'b1;
        endcase
      3'b001, 3'b010: alu = a + b;
      3'b011: alu = a & b;
      3'b100: alu = a | b;
      3'b110: alu = a - b;
      3'b111: alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: ill = 1'b1;
    endcase
  end
  // p holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    msum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, d} : '0);
    mstep = {msum, p[WIDTH-1:1]};
    dsh = {p, 1'b0};
    ddiff = {1'b0, dsh[2*WIDTH:WIDTH]} - {2'b0, d};
    dstep = ddiff[WIDTH+1] ? dsh[2*WIDTH-1:0] : {ddiff[WIDTH-1:0], dsh[WIDTH-1:1], 1'b1};
  end
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = (acc && is_mul) ? MUL : (acc && is_div) ? DIV : IDLE;
    else if (done)
      state_n = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      p <= '0;
      d <= '0;
      result <= '0;
      zero <= 1'b0;
      illegal <= 1'b0;
      out_valid <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (acc && is_mul) begin
          p <= {{WIDTH{1'b0}}, b};
          d <= a;
        end else if (acc && is_div) begin
          p <= {{WIDTH{1'b0}}, a};
          d <= b;
        end else if (acc) begin
          result <= alu;
          zero <= (alu == '0);
          illegal <= ill;
          out_valid <= 1'b1;
        end
      end else if (done) begin
        hi <= p[2*WIDTH-1:WIDTH];
        lo <= p[WIDTH-1:0];
        result <= p[WIDTH-1:0];
        zero <= (p[WIDTH-1:0] == '0);
        illegal <= 1'b0;
        out_valid <= 1'b1;
      end else begin
        p <= (state == MUL) ? mstep : dstep;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed stimulus with a cycle-level reference model and literal spot checks.
module tb_exec_unit;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic in_ready, zero, illegal, out_valid;
  logic [2:0] aluop = '0;
  logic [5:0] func = '0;
  logic [4:0] shamt = '0;
  logic [W-1:0] a = '0, b = '0, result, hi, lo;
  int checks = 0, failures = 0;
  logic chk_on = 1'b0;
  exec_unit #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .func(func), .shamt(shamt), .a(a), .b(b),
    .result(result), .zero(zero), .illegal(illegal), .out_valid(out_valid),
    .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  int m_busy;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo, e_res, mr, ph, pl;
  logic e_ov, e_z, e_ill, mil, mlong;
  logic [63:0] prod;
  always_comb begin
    mr = '0;
    mil = 1'b0;
    mlong = 1'b0;
    prod = 64'(a) * 64'(b);
    ph = '0;
    pl = '0;
    case (aluop)
      3'd0:
        case (func)
          6'h20: mr = a + b;
          6'h22: mr = a - b;
          6'h24: mr = a & b;
          6'h25: mr = a | b;
          6'h27: mr = ~(a | b);
          6'h2a: mr = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h00: mr = b << shamt;
          6'h02: mr = b >> shamt;
          6'h19: begin mlong = 1'b1; ph = prod[63:32]; pl = prod[31:0]; end
          6'h1b: begin mlong = 1'b1; ph = (b == 0) ? a : a % b; pl = (b == 0) ? '1 : a / b; end
          6'h10: mr = m_hi;
          6'h12: mr = m_lo;
          default: mil = 1'b1;
        endcase
      3'd1, 3'd2: mr = a + b;
      3'd3: mr = a & b;
      3'd4: mr = a | b;
      3'd6: mr = a - b;
      3'd7: mr = ($signed(a) < $signed(b)) ? 1 : 0;
      default: mil = 1'b1;
    endcase
  end
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0;
      e_ov <= 1'b0; e_res <= '0; e_z <= 1'b0; e_ill <= 1'b0;
    end else begin
      e_ov <= 1'b0;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; e_ov <= 1'b1;
          e_res <= p_lo; e_z <= (p_lo == 0); e_ill <= 1'b0;
        end
      end else if (in_valid && mlong) begin
        m_busy <= W + 1; p_hi <= ph; p_lo <= pl;
      end else if (in_valid) begin
        e_ov <= 1'b1; e_res <= mr; e_z <= (mr == 0); e_ill <= mil;
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_on) begin
    chk("m_out_valid", 64'(out_valid), 64'(e_ov));
    chk("m_in_ready", 64'(in_ready), 64'(m_busy == 0));
    chk("m_result", 64'(result), 64'(e_res));
    chk("m_zero", 64'(zero), 64'(e_z));
    chk("m_illegal", 64'(illegal), 64'(e_ill));
    chk("m_hi", 64'(hi), 64'(m_hi));
    chk("m_lo", 64'(lo), 64'(m_lo));
  end
  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    aluop = op; func = fn; shamt = sh; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic longop(input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    int lat, busy;
    aluop = 3'd0; func = fn; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    if (hold) begin aluop = 3'd1; a = 1; b = 2; end
    else in_valid = 1'b0;
    lat = 0; busy = 0;
    while (lat < 40 && !out_valid) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("long_latency", 64'(lat), 64'(W + 1));
    chk("long_busy", 64'(busy), 64'(lat));
  endtask
  initial begin
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_hi_lo", {hi, lo}, 64'd0);
    chk("rst_result", 64'({result, zero, illegal, out_valid}), 64'd0);
    rst = 1'b0;
    drive(3'd0, 6'b100010, 0, 5, 7);
    chk("sub_res", 64'(result), 64'hFFFFFFFE);
    chk("sub_flags", 64'({zero, out_valid}), 64'b01);
    drive(3'd6, 6'h3f, 0, 32'h1234, 32'h1234);
    chk("sub_zero", 64'({result, zero}), 64'b1);
    drive(3'd5, 6'h20, 0, 3, 4);
    chk("illegal_op", 64'({result, illegal}), 64'b1);
    drive(3'd0, 6'b111111, 0, 3, 4);
    chk("illegal_func", 64'(illegal), 64'd1);
    drive(3'd7, 6'h00, 0, 32'hFFFFFFFF, 1);
    chk("slt_neg", 64'(result), 64'd1);
    drive(3'd0, 6'b100111, 0, 0, 0);
    chk("nor", 64'(result), 64'hFFFFFFFF);
    drive(3'd2, 6'h00, 0, 32'hFFFFFFFF, 2);
    chk("add_wrap", 64'(result), 64'd1);
    drive(3'd0, 6'b000010, 4, 0, 32'hF0);
    chk("srl", 64'(result), 64'hF);
    drive(3'd0, 6'b000000, 31, 0, 1);
    chk("sll31", 64'(result), 64'h80000000);
    longop(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("mul_hi_lo", {hi, lo}, 64'hFFFFFFFE_00000001);
    @(negedge clk);
    chk("no_second_pulse", 64'(out_valid), 64'd0);
    drive(3'd0, 6'b010000, 0, 0, 0);
    chk("mfhi", 64'(result), 64'hFFFFFFFE);
    drive(3'd0, 6'b010010, 0, 0, 0);
    chk("mflo", 64'(result), 64'd1);
    longop(6'b011011, 100, 7, 1'b0);
    chk("div_hi_lo", {hi, lo}, {32'd2, 32'd14});
    longop(6'b011011, 9, 0, 1'b0);
    chk("div0_hi_lo", {hi, lo}, {32'd9, 32'hFFFFFFFF});
    longop(6'b011001, 32'h10000, 32'h30000, 1'b0);
    chk("mul_small", {hi, lo}, 64'h3_00000000);
    chk("mul_zero_flag", 64'(zero), 64'd1);
    drive(3'd0, 6'b011011, 0, 1000, 3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 64'({in_ready, out_valid}), 64'b10);
    chk("abort_hi_lo", {hi, lo}, 64'd0);
    begin
      int pulses = 0;
      repeat (40) begin @(negedge clk); if (out_valid) pulses++; end
      chk("abort_no_pulse", 64'(pulses), 64'd0);
    end
    rst = 1'b1;
    aluop = 3'd1; a = 3; b = 4; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_vs_accept", 64'({result, out_valid}), 64'd0);
    @(negedge clk);
    chk("rst_drop", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
